mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of a single-port RAM.
//
// Each granted access walks IDLE -> ACCESS -> WAIT -> RESP -> IDLE, one edge
// per step.  The winning request (rw/addr/wdata/owner) is latched on the grant
// edge and later request changes are ignored.  The RAM response is registered
// by the RAM and is sampled on the WAIT->RESP edge into the owner's rdata/err.
// Addresses >= MEM_END never reach the RAM bus and complete with err=1,
// rdata=0 and the same latency.
//
// Optional feature macro: MEM_ARB_RR_EN
//   defined   : round-robin between the masters on simultaneous requests
//   undefined : fixed priority, m1 (CPU data) always wins
//
// Ports
//   clk, rst_n                : clock, asynchronous active-low reset
//   m0_* / m1_*               : requester ports (m0 = CPU fetch, m1 = CPU data)
//     *_req, *_rw, *_addr, *_wdata : request (rw: 1 = write, 0 = read)
//     *_ack                   : one-cycle completion pulse (RESP cycle)
//     *_rdata, *_err          : response, held until that master's next RESP
//   mem_valid, mem_rw, mem_addr, mem_write : RAM request bus
//   mem_read, mem_exception   : registered RAM response
//   dbg_state_o               : current FSM state (IDLE=0 ACCESS=1 WAIT=2 RESP=3)
//
// Handshake: a master raises req with its rw/addr/wdata valid; the request is
// taken only when sampled in IDLE.  Completion is the single-cycle ack; rdata
// and err are meaningful while ack is high and stay stable afterwards.
module mem_arbiter #(
   parameter int unsigned        ADDR_W  = 64,
   parameter int unsigned        DATA_W  = 64,
   parameter logic [ADDR_W-1:0]  MEM_END = 'h1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_rw,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_rw,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,
   output logic              mem_valid,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write,
   input  logic [DATA_W-1:0] mem_read,
   input  logic              mem_exception,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;   // 0 = m0, 1 = m1
   logic                rw_q, rw_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                oor_q, oor_d;       // latched address is out of range
   logic                prio_q, prio_d;     // 1 = m1 preferred on a tie
   logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic                err0_q, err0_d, err1_q, err1_d;
   logic                grant1;

   // Winner when at least one request is present.
`ifdef MEM_ARB_RR_EN
   assign grant1 = m1_req & (~m0_req | prio_q);
`else
   assign grant1 = m1_req;
`endif

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rw_d     = rw_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      oor_d    = oor_q;
      prio_d   = prio_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      err0_d   = err0_q;
      err1_d   = err1_q;
      case (state_q)
         S_IDLE: begin
            if (m0_req | m1_req) begin
               state_d = S_ACCESS;
               owner_d = grant1;
               rw_d    = grant1 ? m1_rw    : m0_rw;
               addr_d  = grant1 ? m1_addr  : m0_addr;
               wdata_d = grant1 ? m1_wdata : m0_wdata;
               oor_d   = (grant1 ? m1_addr : m0_addr) >= MEM_END;
               // Pointer moves to the master that was not just served.
               prio_d  = ~grant1;
            end
         end
         S_ACCESS: state_d = S_WAIT;
         S_WAIT: begin
            state_d = S_RESP;
            // RAM response is valid during WAIT; out-of-range reports err, rdata=0.
            if (owner_q) begin
               rdata1_d = oor_q ? '0 : mem_read;
               err1_d   = oor_q | mem_exception;
            end else begin
               rdata0_d = oor_q ? '0 : mem_read;
               err0_d   = oor_q | mem_exception;
            end
         end
         S_RESP:  state_d = S_IDLE;   // no grant here by design
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         owner_q  <= 1'b0;
         rw_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         oor_q    <= 1'b0;
         prio_q   <= 1'b1;
         rdata0_q <= '0;
         rdata1_q <= '0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rw_q     <= rw_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         oor_q    <= oor_d;
         prio_q   <= prio_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         err0_q   <= err0_d;
         err1_q   <= err1_d;
      end
   end

   assign mem_valid   = (state_q == S_ACCESS) & ~oor_q;
   assign mem_rw      = mem_valid & rw_q;
   assign mem_addr    = addr_q;
   assign mem_write   = wdata_q;
   assign m0_ack      = (state_q == S_RESP) & ~owner_q;
   assign m1_ack      = (state_q == S_RESP) &  owner_q;
   assign m0_rdata    = rdata0_q;
   assign m1_rdata    = rdata1_q;
   assign m0_err      = err0_q;
   assign m1_err      = err1_q;
   assign dbg_state_o = state_q;

endmodule
